// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, fixed-latency unified memory between instruction fetch
// and load/store; data wins ties unless fetch has lost STARVE_MAX contested rounds.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (MEM_LAT    < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             owner_d;
  logic             grant_d;
  logic             grant_f;
  logic             lat_zero;
  logic             contested;

  assign lat_zero  = (lat_cnt == '0);
  assign contested = if_req && d_req;

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_f = 1'b1;
        end
        if (grant_d || grant_f) begin
          state_nxt = ACCESS;
        end
      end
      // lat_cnt reaches zero in exactly the cycle mem_rdata is valid
      ACCESS: begin
        if (lat_zero) begin
          state_nxt = DONE;
        end
      end
      // No grant here: a requester still holding req from the finished access is not re-served.
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state   <= state_nxt;
      mem_en  <= grant_d || grant_f;
      if_done <= 1'b0;
      d_done  <= 1'b0;

      if (grant_d) begin
        owner_d   <= 1'b1;
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
        lat_cnt   <= LAT_INIT;
        if (contested) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (grant_f) begin
        owner_d    <= 1'b0;
        mem_addr   <= if_addr;
        mem_we     <= 1'b0;
        lat_cnt    <= LAT_INIT;
        starve_cnt <= '0;
      end

      if (state == ACCESS) begin
        if (lat_zero) begin
          if (owner_d) begin
            d_done <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end else begin
            if_done  <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
    end
  end

  assign if_stall = if_req && !if_done;
  assign d_stall  = d_req && !d_done;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model and a fixed-latency memory responder.
module tb_unified_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_done, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_done, d_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;
  int last_if_cyc, last_d_cyc;
  logic prev_if_done = 1'b0;
  logic prev_d_done  = 1'b0;
  string done_log;

  // memory seen through the DUT's strobes, and the model's view of memory
  logic [31:0] phys_mem [16];
  logic [31:0] ref_mem  [16];
  int          rd_due_q [$];
  logic [31:0] rd_val_q [$];

  // reference model: at most one outstanding transaction granted at cycle m_g
  logic        m_act = 1'b0;
  int          m_g   = 0;
  logic        m_own_d, m_we;
  logic [31:0] m_addr, m_wdata, m_rd;
  int          m_starve = 0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata  = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = $urandom;
    while (rd_due_q.size() > 0 && rd_due_q[0] < cyc) begin
      void'(rd_due_q.pop_front());
      void'(rd_val_q.pop_front());
    end
    if (rd_due_q.size() > 0 && rd_due_q[0] == cyc) begin
      void'(rd_due_q.pop_front());
      mem_rdata = rd_val_q.pop_front();
    end
  endtask

  task automatic end_cycle();
    logic e_en, e_ifd, e_dd, e_busy, was_act, gd, gf;
    @(negedge clk);
    if (reset) begin
      m_act      = 1'b0;
      m_starve   = 0;
      m_if_rdata = '0;
      m_d_rdata  = '0;
    end
    e_en   = m_act && (cyc == m_g + 1);
    e_ifd  = m_act && (cyc == m_g + LAT + 2) && !m_own_d;
    e_dd   = m_act && (cyc == m_g + LAT + 2) && m_own_d;
    e_busy = m_act && (cyc > m_g) && (cyc <= m_g + LAT + 2);
    if (e_en) begin
      if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
      else m_rd = ref_mem[m_addr[5:2]];
    end
    if (e_ifd) m_if_rdata = m_rd;
    if (e_dd && !m_we) m_d_rdata = m_rd;

    check("mem_en", mem_en, e_en);
    if (e_en || reset) begin
      check("mem_addr", mem_addr, reset ? 32'd0 : m_addr);
      check("mem_we", mem_we, reset ? 1'b0 : m_we);
      if (reset || m_we) check("mem_wdata", mem_wdata, reset ? 32'd0 : m_wdata);
    end
    check("if_done", if_done, e_ifd);
    check("d_done", d_done, e_dd);
    check("if_rdata", if_rdata, m_if_rdata);
    check("d_rdata", d_rdata, m_d_rdata);
    check("busy", busy, e_busy);
    check("if_stall", if_stall, if_req && !e_ifd);
    check("d_stall", d_stall, d_req && !e_dd);

    if (if_done) begin done_log = {done_log, "F"}; last_if_cyc = cyc; end
    if (d_done)  begin done_log = {done_log, "D"}; last_d_cyc  = cyc; end
    prev_if_done = if_done;
    prev_d_done  = d_done;

    if (mem_en) begin
      if (mem_we) phys_mem[mem_addr[5:2]] = mem_wdata;
      else begin
        rd_due_q.push_back(cyc + LAT);
        rd_val_q.push_back(phys_mem[mem_addr[5:2]]);
      end
    end

    was_act = m_act;
    if (e_ifd || e_dd) m_act = 1'b0;
    if (!reset && !was_act) begin
      gd = 1'b0;
      gf = 1'b0;
      if (d_req && if_req) begin
        if (m_starve < SMAX) begin gd = 1'b1; m_starve++; end
        else gf = 1'b1;
      end else if (d_req) gd = 1'b1;
      else if (if_req) gf = 1'b1;
      if (gf) m_starve = 0;
      if (gd || gf) begin
        m_act   = 1'b1;
        m_g     = cyc;
        m_own_d = gd;
        m_addr  = gd ? d_addr : if_addr;
        m_we    = gd && d_we;
        m_wdata = d_wdata;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      reset  = 1'b0;
      if_req = 1'b0;
      d_req  = 1'b0;
      end_cycle();
    end
  endtask

  task automatic rand_drive();
    if (!if_req || prev_if_done) begin
      if ($urandom_range(0, 3) != 0) begin
        if_req  = 1'b1;
        if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end else if_req = 1'b0;
    end
    if (!d_req || prev_d_done) begin
      if ($urandom_range(0, 3) != 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        d_wdata = $urandom;
      end else d_req = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] packed_log;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = i * 32'h0101_0101;
      ref_mem[i]  = i * 32'h0101_0101;
    end
    repeat (3) begin begin_cycle(); end_cycle(); end
    idle(1);

    // single fetch with the address changing after the grant
    phys_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    phys_mem[8] = 32'h1234_5678; ref_mem[8] = 32'h1234_5678;
    last_if_cyc = -1;
    for (int k = 0; k <= 4; k++) begin
      begin_cycle();
      if (k == 0) t0 = cyc;
      if_req  = 1'b1;
      if_addr = (k >= 2) ? 32'h20 : 32'h10;
      end_cycle();
    end
    idle(2);
    check("fetch_latency", last_if_cyc - t0, 4);
    check("fetch_data", if_rdata, 32'hDEAD_BEEF);

    // contention: store wins, fetch follows
    last_if_cyc = -1; last_d_cyc = -1;
    for (int k = 0; k <= 9; k++) begin
      begin_cycle();
      if (k == 0) t0 = cyc;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = (k <= 4); d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55;
      end_cycle();
    end
    idle(2);
    check("contend_d_latency", last_d_cyc - t0, 4);
    check("contend_f_latency", last_if_cyc - t0, 9);
    check("contend_d_rdata", d_rdata, 32'h0);

    // starvation limit with both requesters saturating
    done_log = ""; d_addr = '0; d_we = 1'b0;
    for (int k = 0; k < 30; k++) begin
      begin_cycle();
      if (prev_d_done) d_addr = d_addr + 32'd4;
      d_req = 1'b1; if_req = 1'b1;
      end_cycle();
    end
    idle(3);
    check("starve_count", done_log.len(), 6);
    packed_log = '0;
    for (int i = 0; i < done_log.len(); i++) packed_log = {packed_log[55:0], 8'(done_log[i])};
    check("starve_order", packed_log, {16'h0, "DDFDDF"});

    // reset in the middle of a load, then a fresh load
    phys_mem[2] = 32'hA5A5_0001; ref_mem[2] = 32'hA5A5_0001;
    begin_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14; end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); reset = 1'b1; d_req = 1'b0; end_cycle();
    begin_cycle(); reset = 1'b0; end_cycle();
    idle(2);
    last_d_cyc = -1;
    for (int k = 0; k <= 4; k++) begin
      begin_cycle();
      if (k == 0) t0 = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
      end_cycle();
    end
    idle(1);
    check("reset_reload_latency", last_d_cyc - t0, 4);
    check("reset_reload_data", d_rdata, 32'hA5A5_0001);

    // request dropped during the access still completes
    last_d_cyc = -1;
    for (int k = 0; k <= 6; k++) begin
      begin_cycle();
      if (k == 0) t0 = cyc;
      d_req = (k < 2); d_we = 1'b0; d_addr = 32'h0C;
      end_cycle();
    end
    check("drop_latency", last_d_cyc - t0, 4);
    check("drop_data", d_rdata, 32'h0303_0303);

    // random traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      begin_cycle();
      reset = ($urandom_range(0, 63) == 0);
      rand_drive();
      end_cycle();
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between two requesters of the 5-stage RV32 pipeline: the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Issues one transaction at a time to a fixed-latency memory and returns a one-cycle done pulse with read data to the winner.
- Generates per-port stall signals for the pipeline.
- Fixed priority is data over fetch, with a starvation limit that forces a fetch grant.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid (>=1)
STARVE_MAX, 4, consecutive contested losses after which fetch wins (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetched word, valid with if_done, held until next fetch done
if_stall  out  1  if_req && !if_done (combinational)
d_req  in  1  data request; held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_done  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  load data, valid with d_done; unchanged by stores
d_stall  out  1  d_req && !d_done (combinational)
mem_en  out  1  one-cycle memory strobe
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after the mem_en cycle
busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-high, on clk domain.
  - Sets state=IDLE and all registered outputs (mem_en, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata) to 0.
  - Clears starve_cnt and the latency counter.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration sampled at the clk edge:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both, starve_cnt < STARVE_MAX: grant data, starve_cnt++.
  - Both, starve_cnt == STARVE_MAX: grant fetch.
  - Any fetch grant clears starve_cnt. An uncontested data grant leaves starve_cnt unchanged.
- Grant edge:
  - Registers owner, mem_addr, mem_we (d_we for data, 0 for fetch) and mem_wdata (d_wdata for data, unchanged for fetch).
  - Sets mem_en=1 for exactly the next cycle, loads lat_cnt=MEM_LAT, state goes to ACCESS.
  - Requester inputs that change after the grant edge are ignored.
- ACCESS:
  - lat_cnt decrements each cycle.
  - In the cycle mem_rdata is valid (MEM_LAT cycles after the mem_en cycle), it is captured into the owner's rdata register on read transactions only.
  - State then goes to DONE.
- DONE:
  - The owner's done output is 1 for this single cycle.
  - Next state is IDLE unconditionally; there is no grant from DONE, so a requester still holding req here is not re-served.
- Timing:
  - Request seen at edge ending cycle 0: mem_en in cycle 1, done in cycle MEM_LAT+2.
  - Next grant is possible no earlier than the edge ending cycle MEM_LAT+3.
- New requests: req high in the cycle after done is a new request using the addr/data presented then. Requesters never see both done pulses in the same cycle.
- Early deassert: if req drops during ACCESS, the transaction still completes and done still pulses.
- Reset mid-ACCESS/DONE: the transaction is aborted with no done pulse, and a late mem_rdata is ignored.

Test Plan:
- Single fetch (MEM_LAT=2): if_req=1, if_addr=0x10 in cycle 0; mem_rdata=0xDEADBEEF in cycle 3 -> mem_en=1, mem_we=0, mem_addr=0x10 in cycle 1 only; if_done=1 and if_rdata=0xDEADBEEF in cycle 4; if_stall=1 in cycles 0-3.
- Contention: if_req and d_req (store, d_addr=0x100, d_wdata=0x55) both in cycle 0 -> cycle 1 mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0x55; d_done in cycle 4; fetch mem_en in cycle 6; if_done in cycle 9; d_rdata unchanged.
- Starvation (STARVE_MAX=2): both reqs held continuously with data addr incrementing -> grant order D,D,F,D,D,F.
- Input hold: if_addr changes 0x10->0x20 in cycle 2 of a fetch -> mem_addr stays 0x10; if_rdata reflects the 0x10 access.
- Reset mid-ACCESS: reset pulsed in cycle 2 -> all outputs 0 immediately; busy=0; no done pulse for the aborted transaction; a fresh d_req load after release completes with correct d_rdata at MEM_LAT+2.
- Early drop: d_req deasserted in cycle 2 of a load -> d_done still pulses in cycle 4; no new grant follows.
